// File: rtl/fetch_instruction_queue.sv
// Fetch-to-decode instruction queue with slot reservation for in-flight fetches.
// Entries appear one cycle after push; flush and rst drop everything queued.
module fetch_instruction_queue #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            reserve,
    output logic            space_available,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic [31:0]     push_pc,
    input  logic [31:0]     push_instruction,
    input  logic            push_ok,
    output logic            out_valid,
    output logic [ID_W-1:0] out_id,
    output logic [31:0]     out_pc,
    output logic [31:0]     out_instruction,
    output logic            out_ok,
    input  logic            pop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] P_ONE   = PW'(1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW:0]   DEPTH_T = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     pc;
        logic [31:0]     instruction;
        logic            ok;
    } entry_t;

    entry_t mem [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] occupied;
    logic [CW-1:0] outstanding;
    logic [CW:0]   claimed;
    logic          pop_eff;
    entry_t        head;

    assign claimed         = {1'b0, occupied} + {1'b0, outstanding};
    assign space_available = claimed < DEPTH_T;
    assign out_valid       = occupied != '0;
    assign pop_eff         = pop && out_valid;

    assign head            = mem[rd_ptr];
    assign out_id          = head.id;
    assign out_pc          = head.pc;
    assign out_instruction = head.instruction;
    assign out_ok          = head.ok;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occupied    <= '0;
            outstanding <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + P_ONE;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + P_ONE;
            end
            case ({push, pop_eff})
                2'b10:   occupied <= occupied + C_ONE;
                2'b01:   occupied <= occupied - C_ONE;
                default: occupied <= occupied;
            endcase
            case ({reserve, push})
                2'b10:   outstanding <= outstanding + C_ONE;
                2'b01:   outstanding <= outstanding - C_ONE;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Data storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            mem[wr_ptr] <= '{
                id:          push_id,
                pc:          push_pc,
                instruction: push_instruction,
                ok:          push_ok
            };
        end
    end

`ifndef SYNTHESIS
    a_push_unclaimed: assert property (
        @(posedge clk) disable iff (rst || flush)
        !(push && outstanding == '0));

    a_reserve_full: assert property (
        @(posedge clk) disable iff (rst || flush)
        !(reserve && !space_available));

    a_push_overflow: assert property (
        @(posedge clk) disable iff (rst || flush)
        !(push && occupied == FULL));
`endif

endmodule

// File: tb/tb_fetch_instruction_queue.sv
// Directed bench for fetch_instruction_queue: vector table plus
// hand sequences for wrap-around, simultaneous events and flush.
module tb_fetch_instruction_queue;

    localparam int DEPTH = 4;
    localparam int ID_W  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            reserve;
    logic            space_available;
    logic            push;
    logic [ID_W-1:0] push_id;
    logic [31:0]     push_pc;
    logic [31:0]     push_instruction;
    logic            push_ok;
    logic            out_valid;
    logic [ID_W-1:0] out_id;
    logic [31:0]     out_pc;
    logic [31:0]     out_instruction;
    logic            out_ok;
    logic            pop;

    int total  = 0;
    int passed = 0;

    fetch_instruction_queue #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .reserve          (reserve),
        .space_available  (space_available),
        .push             (push),
        .push_id          (push_id),
        .push_pc          (push_pc),
        .push_instruction (push_instruction),
        .push_ok          (push_ok),
        .out_valid        (out_valid),
        .out_id           (out_id),
        .out_pc           (out_pc),
        .out_instruction  (out_instruction),
        .out_ok           (out_ok),
        .pop              (pop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            r;
        logic            f;
        logic            res;
        logic            pu;
        logic            po;
        logic [ID_W-1:0] id;
        logic [31:0]     pc;
        logic [31:0]     ins;
        logic            ok;
        logic            e_valid;
        logic            e_space;
        logic [ID_W-1:0] e_id;
        logic [31:0]     e_pc;
        logic [31:0]     e_ins;
        logic            e_ok;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(
        input logic r, f, res, pu, po,
        input logic [ID_W-1:0] id,
        input logic [31:0] pc, ins,
        input logic ok, ev, es,
        input logic [ID_W-1:0] eid,
        input logic [31:0] epc, eins,
        input logic eok);
        vec_t v;
        v.r = r; v.f = f; v.res = res; v.pu = pu; v.po = po;
        v.id = id; v.pc = pc; v.ins = ins; v.ok = ok;
        v.e_valid = ev; v.e_space = es; v.e_id = eid;
        v.e_pc = epc; v.e_ins = eins; v.e_ok = eok;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            passed++;
    endtask

    task automatic drive(input logic r, f, res, pu, po, input logic [31:0] pc);
        rst              = r;
        flush            = f;
        reserve          = res;
        push             = pu;
        pop              = po;
        push_pc          = pc;
        push_id          = pc[ID_W+1:2];
        push_instruction = {pc[15:0], 16'h0013};
        push_ok          = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bounds(input string name);
        chk({name, "_occ_le4"}, 32'(dut.occupied <= 4), 32'd1);
        chk({name, "_out_le4"}, 32'(dut.outstanding <= 4), 32'd1);
    endtask

    logic [31:0] q [$];
    logic [31:0] next_pc;
    int          wcount;
    int          rcount;

    initial begin
        vecs[0]  = mk(1,0,0,0,0, 0, 0, 0, 1,   0,1, 0, 0, 0, 0);
        vecs[1]  = mk(0,0,1,0,0, 0, 0, 0, 1,   0,1, 0, 0, 0, 0);
        vecs[2]  = mk(0,0,1,0,0, 0, 0, 0, 1,   0,1, 0, 0, 0, 0);
        vecs[3]  = mk(0,0,1,0,0, 0, 0, 0, 1,   0,1, 0, 0, 0, 0);
        vecs[4]  = mk(0,0,1,0,0, 0, 0, 0, 1,   0,0, 0, 0, 0, 0);
        vecs[5]  = mk(0,0,0,1,0, 1, 32'h100, 32'h1000_0013, 1,
                      1,0, 1, 32'h100, 32'h1000_0013, 1);
        vecs[6]  = mk(0,0,0,1,0, 2, 32'h104, 32'h1040_0013, 1,
                      1,0, 1, 32'h100, 32'h1000_0013, 1);
        vecs[7]  = mk(0,0,0,1,0, 3, 32'h108, 32'h1080_0013, 1,
                      1,0, 1, 32'h100, 32'h1000_0013, 1);
        vecs[8]  = mk(0,0,0,1,0, 4, 32'h10C, 32'h10C0_0013, 1,
                      1,0, 1, 32'h100, 32'h1000_0013, 1);
        vecs[9]  = mk(0,0,0,0,0, 0, 0, 0, 1,
                      1,0, 1, 32'h100, 32'h1000_0013, 1);
        vecs[10] = mk(0,0,0,0,1, 0, 0, 0, 1,
                      1,1, 2, 32'h104, 32'h1040_0013, 1);
        vecs[11] = mk(0,0,0,0,1, 0, 0, 0, 1,
                      1,1, 3, 32'h108, 32'h1080_0013, 1);
        vecs[12] = mk(0,0,0,0,1, 0, 0, 0, 1,
                      1,1, 4, 32'h10C, 32'h10C0_0013, 1);
        vecs[13] = mk(0,0,0,0,1, 0, 0, 0, 1,   0,1, 0, 0, 0, 0);
        vecs[14] = mk(0,0,0,0,1, 0, 0, 0, 1,   0,1, 0, 0, 0, 0);
        vecs[15] = mk(0,0,1,0,0, 0, 0, 0, 1,   0,1, 0, 0, 0, 0);
        vecs[16] = mk(0,0,0,1,0, 5, 32'h200, 32'hDEADBEEF, 0,
                      1,1, 5, 32'h200, 32'hDEADBEEF, 0);
        vecs[17] = mk(0,0,1,0,0, 0, 0, 0, 1,
                      1,1, 5, 32'h200, 32'hDEADBEEF, 0);
        vecs[18] = mk(0,0,0,1,0, 6, 32'h204, 32'h2040_0013, 1,
                      1,1, 5, 32'h200, 32'hDEADBEEF, 0);
        vecs[19] = mk(1,1,1,0,1, 0, 0, 0, 1,   0,1, 0, 0, 0, 0);

        drive(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20; i++) begin
            rst              = vecs[i].r;
            flush            = vecs[i].f;
            reserve          = vecs[i].res;
            push             = vecs[i].pu;
            pop              = vecs[i].po;
            push_id          = vecs[i].id;
            push_pc          = vecs[i].pc;
            push_instruction = vecs[i].ins;
            push_ok          = vecs[i].ok;
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_space", i), 32'(space_available), 32'(vecs[i].e_space));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_id", i), 32'(out_id), 32'(vecs[i].e_id));
                chk($sformatf("v%0d_pc", i), out_pc, vecs[i].e_pc);
                chk($sformatf("v%0d_ins", i), out_instruction, vecs[i].e_ins);
                chk($sformatf("v%0d_ok", i), 32'(out_ok), 32'(vecs[i].e_ok));
            end
        end
        chk("rst_rd_ptr", 32'(dut.rd_ptr), 32'd0);
        chk("rst_wr_ptr", 32'(dut.wr_ptr), 32'd0);

        // Wrap-around with occupancy moving between 1 and 3.
        next_pc = 32'h1000;
        wcount  = 0;
        rcount  = 0;
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 0, next_pc); tick();
        q.push_back(next_pc);
        next_pc += 4;
        wcount++;
        for (int i = 0; i < 10; i++) begin
            automatic int n = (i % 3 == 2) ? 2 : 1;
            for (int k = 0; k < n; k++) begin
                drive(0, 0, 1, 0, 0, 0); tick();
                bounds($sformatf("w%0d_res", i));
            end
            for (int k = 0; k < n; k++) begin
                drive(0, 0, 0, 1, 0, next_pc); tick();
                q.push_back(next_pc);
                next_pc += 4;
                wcount++;
                bounds($sformatf("w%0d_push", i));
            end
            for (int k = 0; k < n; k++) begin
                chk($sformatf("w%0d_pc", i), out_pc, q[0]);
                drive(0, 0, 0, 0, 1, 0); tick();
                void'(q.pop_front());
                rcount++;
            end
            chk($sformatf("w%0d_wr_ptr", i), 32'(dut.wr_ptr), 32'(wcount % DEPTH));
            chk($sformatf("w%0d_rd_ptr", i), 32'(dut.rd_ptr), 32'(rcount % DEPTH));
        end
        chk("wrap_head", out_pc, q[0]);

        // occupied=1, outstanding=1, then reserve+push+pop together.
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 1, 1, 1, 32'h3000); tick();
        chk("sim_occ", 32'(dut.occupied), 32'd1);
        chk("sim_outst", 32'(dut.outstanding), 32'd1);
        chk("sim_pc", out_pc, 32'h3000);

        // Build occupied=3, outstanding=1, then flush with everything.
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 1, 0, 0, 0); tick();
        chk("pre_fl_space", 32'(space_available), 32'd0);
        drive(0, 0, 0, 1, 0, 32'h3004); tick();
        drive(0, 0, 0, 1, 0, 32'h3008); tick();
        chk("pre_fl_occ", 32'(dut.occupied), 32'd3);
        chk("pre_fl_outst", 32'(dut.outstanding), 32'd1);
        drive(0, 1, 1, 1, 1, 32'h3010); tick();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_space", 32'(space_available), 32'd1);
        chk("fl_occ", 32'(dut.occupied), 32'd0);
        chk("fl_outst", 32'(dut.outstanding), 32'd0);
        chk("fl_rd_ptr", 32'(dut.rd_ptr), 32'd0);
        chk("fl_wr_ptr", 32'(dut.wr_ptr), 32'd0);
        drive(0, 0, 1, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 32'h4000);
        #1;
        chk("no_bypass", 32'(out_valid), 32'd0);
        tick();
        chk("pf_valid", 32'(out_valid), 32'd1);
        chk("pf_pc", out_pc, 32'h4000);
        chk("pf_rd_ptr", 32'(dut.rd_ptr), 32'd0);
        chk("pf_wr_ptr", 32'(dut.wr_ptr), 32'd1);
        drive(0, 0, 0, 0, 1, 0); tick();
        chk("end_valid", 32'(out_valid), 32'd0);
        chk("end_space", 32'(space_available), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_instruction_queue.md
FETCH_INSTRUCTION_QUEUE -- requirements
Module: fetch_instruction_queue

Interface
REQ-001 The block SHALL have the following parameters, one per line as name, default and meaning:
- DEPTH, 4, number of entries; power of two, at least 2.
- ID_W, 3, width of the instruction ID.
REQ-002 The block SHALL have the following ports, one per line as name, direction, width and meaning:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discard all queued and in-flight instructions; driven by fetch flush OR early branch flush.
- reserve  in  1  fetch issued a new memory request and claims one slot.
- space_available  out  1  at least one unclaimed slot exists; fetch gates new requests with it.
- push  in  1  fetch result valid (fetch_complete).
- push_id  in  ID_W  instruction ID assigned at fetch.
- push_pc  in  32  instruction PC.
- push_instruction  in  32  instruction word.
- push_ok  in  1  fetch metadata ok; 0 means access fault.
- out_valid  out  1  head entry valid.
- out_id  out  ID_W  head entry ID.
- out_pc  out  32  head entry PC.
- out_instruction  out  32  head entry instruction word.
- out_ok  out  1  head entry ok flag.
- pop  in  1  decode consumes the head entry.

Function
REQ-003 Storage SHALL be a circular buffer of DEPTH entries, each {id, pc, instruction, ok}, with read and write pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-004 The block SHALL track occupied (0..DEPTH) and outstanding (0..DEPTH) counters, each log2(DEPTH)+1 bits.
REQ-005 space_available SHALL equal (occupied + outstanding) < DEPTH, computed combinationally from registered counters.
REQ-006 reserve SHALL increment outstanding. push SHALL decrement outstanding. When reserve and push occur in the same cycle, outstanding SHALL be unchanged.
REQ-007 push SHALL write the entry at the write pointer, advance the write pointer and increment occupied.
REQ-008 An effective pop is pop AND out_valid. It SHALL advance the read pointer and decrement occupied. pop with out_valid=0 SHALL have no effect.
REQ-009 When push and an effective pop occur in the same cycle, occupied SHALL be unchanged and both pointers SHALL advance.
REQ-010 out_valid SHALL equal (occupied != 0). The out_* fields SHALL be read combinationally from the entry at the read pointer.
REQ-011 Latency SHALL be one cycle: data pushed in cycle N is presented at the outputs in cycle N+1 at the earliest. There is no same-cycle bypass.
REQ-012 While out_valid=1 and no effective pop occurs, the out_* fields SHALL hold stable.
REQ-013 Entries SHALL be delivered in push order. push_ok=0 entries SHALL be stored and delivered unchanged.
REQ-014 flush SHALL take priority over push, pop and reserve in the same cycle. On the next cycle, pointers, occupied and outstanding SHALL all be 0, out_valid SHALL be 0 and space_available SHALL be 1.
REQ-015 After a flush, fetch guarantees no push for requests issued before the flush. The block SHALL NOT filter such pushes itself.
REQ-016 The following are illegal and SHALL be flagged by simulation assertions, with rst and flush disabling the check:
- push with outstanding=0;
- reserve with space_available=0;
- push with occupied=DEPTH.

Reset
REQ-017 rst=1 at a rising edge SHALL clear the pointers, occupied and outstanding. From the following cycle, out_valid=0 and space_available=1.
REQ-018 rst SHALL override flush, push, pop and reserve. Stored entry data SHALL NOT need to be reset.
REQ-019 rst asserted mid-operation, with entries queued and requests outstanding, SHALL discard all of them identically to REQ-017.

Verification
REQ-020 Fill and drain: DEPTH=4; 4 reserves, then pushes with PC 0x100, 0x104, 0x108, 0x10C, no pop.
- space_available=0 after the 4th reserve.
- out_pc=0x100 held stable.
- Then 4 pops deliver 0x100..0x10C in order.
- out_valid=0 afterwards and space_available=1.
REQ-021 Wrap-around: 10 reserve/push/pop sequences with an occupancy of 1-3.
- The read and write pointers wrap past 3 to 0.
- Order and data are preserved.
- occupied and outstanding never exceed 4.
REQ-022 Simultaneous events:
- occupied=1, outstanding=1, with reserve, push and pop in one cycle.
- Required: next cycle occupied=1, outstanding=1, and out_pc equals the pushed PC.
REQ-023 Flush priority:
- occupied=3, outstanding=1, with flush, push, pop and reserve in one cycle.
- Required: next cycle out_valid=0, space_available=1, both counters 0.
- The next push is written at index 0.
REQ-024 Fault entry and reset:
- Push with push_ok=0 and instruction 0xDEADBEEF -> out_ok=0 and out_instruction=0xDEADBEEF.
- rst asserted with 2 entries queued -> out_valid=0 and space_available=1 the next cycle.
